divider: RTL

// - Iterative radix-2 restoring divider; inverse-operation partner of the RV32M multiplier.
// - Executes DIV, DIVU, REM and REMU for the RV32M accelerator.
// - Sits beside the multiplier and is driven by the same issue logic.
// - Uses a start/done handshake. One operation is in flight at a time.

---
 rtl/rv32m_pkg.sv | 27 ++
 rtl/div_step.sv | 32 +++
 rtl/divider.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M arithmetic blocks: operand width, divider
// FSM encoding, the two corner-case constants, and a sign-magnitude helper.
package rv32m_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [XLEN-1:0]  INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0]  ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    FIX,
    DONE
  } div_state_t;

  // Magnitude of a two's-complement operand; INT_MIN maps to itself and is
  // then treated as an unsigned value by the datapath.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// The trial subtraction is carried one bit wider than the shifted remainder
// so its top bit is a clean sign flag even with the full 33-bit R as input.
module div_step
  import rv32m_pkg::*;
(
  input  logic [XLEN:0]   r_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN:0]   r_o,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN+1:0] w_shift;
  logic [XLEN+1:0] w_trial;

  assign w_shift = {r_i, q_i[XLEN-1]};
  assign w_trial = w_shift - {2'b00, b_i};

  // Keep the trial difference when it stays non-negative, otherwise restore.
  // NOTE: both branches assign every output, so no latch can be inferred.
  always_comb begin
    if (!w_trial[XLEN+1]) begin
      r_o = w_trial[XLEN:0];
      q_o = {q_i[XLEN-2:0], 1'b1};
    end else begin
      r_o = w_shift[XLEN:0];
      q_o = {q_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Start/done handshake, one operation in flight, result held until the next
// accepted start. Optional feature macro: DIV_EARLY_OUT_EN, which lets divide
// by zero and INT_MIN / -1 skip the 32 iteration steps (results unchanged).
module divider
  import rv32m_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] op_A_i,
  input  logic [XLEN-1:0] op_B_i,
  input  logic            signed_i,
  input  logic            rem_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic            done_o
);

  div_state_t       r_state;
  logic [XLEN-1:0]  r_op_a;
  logic [XLEN-1:0]  r_op_b;
  logic             r_signed;
  logic             r_rem;
  logic [XLEN-1:0]  r_b_mag;
  logic [XLEN:0]    r_r;
  logic [XLEN-1:0]  r_q;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_div0;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_result;
  logic             r_busy;
  logic             r_done;

  logic [XLEN-1:0]  w_a_mag;
  logic [XLEN-1:0]  w_b_mag;
  logic             w_div0;
  logic [XLEN:0]    w_r_next;
  logic [XLEN-1:0]  w_q_next;
  logic [XLEN-1:0]  w_quot;
  logic [XLEN-1:0]  w_remd;

  assign w_a_mag = magnitude(r_op_a, r_signed);
  assign w_b_mag = magnitude(r_op_b, r_signed);
  assign w_div0  = (r_op_b == '0);

  // The div0 mask keeps x / 0 at all-ones even when the signs differ.
  assign w_quot = (r_sign_q & ~r_div0) ? -r_q : r_q;
  assign w_remd = r_sign_r ? -r_r[XLEN-1:0] : r_r[XLEN-1:0];

`ifdef DIV_EARLY_OUT_EN
  logic r_early;
  logic w_early;
  logic w_ovf;

  assign w_ovf   = r_signed & (r_op_a == INT_MIN) & (r_op_b == ALL_ONES);
  assign w_early = w_div0 | w_ovf;
`endif

  div_step u_div_step (
    .r_i (r_r),
    .q_i (r_q),
    .b_i (r_b_mag),
    .r_o (w_r_next),
    .q_o (w_q_next)
  );

  // Control FSM and datapath registers, all cleared by synchronous reset.
  // NOTE: non-blocking assignments everywhere here, so every register sees
  // the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_signed <= 1'b0;
      r_rem    <= 1'b0;
      r_b_mag  <= '0;
      r_r      <= '0;
      r_q      <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
      r_early  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_op_a   <= op_A_i;
            r_op_b   <= op_B_i;
            r_signed <= signed_i;
            r_rem    <= rem_i;
            r_busy   <= 1'b1;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_b_mag  <= w_b_mag;
          r_sign_q <= r_signed & (r_op_a[XLEN-1] ^ r_op_b[XLEN-1]);
          r_sign_r <= r_signed & r_op_a[XLEN-1];
          r_div0   <= w_div0;
          r_r      <= '0;
          r_q      <= w_a_mag;
          r_cnt    <= '0;
          r_state  <= DIV;
`ifdef DIV_EARLY_OUT_EN
          // Preset the values the full iteration would have produced:
          // x / 0 gives Q = all-ones, R = |x|; INT_MIN / -1 gives Q = INT_MIN, R = 0.
          r_early <= w_early;
          if (w_early) begin
            r_q <= w_div0 ? ALL_ONES : INT_MIN;
            r_r <= w_div0 ? {1'b0, w_a_mag} : '0;
          end
`endif
        end
        DIV: begin
`ifdef DIV_EARLY_OUT_EN
          if (r_early) begin
            r_state <= FIX;
          end else begin
`endif
            r_r   <= w_r_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
              r_state <= FIX;
            end
`ifdef DIV_EARLY_OUT_EN
          end
`endif
        end
        FIX: begin
          r_result <= r_rem ? w_remd : w_quot;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign busy_o   = r_busy;
  assign done_o   = r_done;

endmodule
